// File: rtl/rx_clock_div_pkg.sv
// Shared definitions for the receive clock divider: gen encodings, divider
// periods and the sequencing FSM states.
package rx_clk_pkg;

    typedef enum logic [1:0] {
        GEN4     = 2'b00,
        GEN3     = 2'b01,
        GEN2     = 2'b10,
        GEN4_ALT = 2'b11
    } gen_e;

    typedef enum logic [1:0] {
        START,
        RUN,
        QUIESCE,
        SWITCH
    } state_e;

    localparam int unsigned SD_GEN4 = 2;
    localparam int unsigned SD_GEN3 = 4;
    localparam int unsigned SD_GEN2 = 8;
    localparam int unsigned DD_GEN4 = 16;
    localparam int unsigned DD_GEN3 = 33;
    localparam int unsigned DD_GEN2 = 66;

    // 11 aliases gen4 so that a 00<->11 change never looks like a gen switch
    function automatic gen_e gen_norm(input logic [1:0] g);
        return (g == GEN4_ALT) ? GEN4 : gen_e'(g);
    endfunction

    function automatic int unsigned sd_period(input gen_e g);
        case (g)
            GEN3:    return SD_GEN3;
            GEN2:    return SD_GEN2;
            default: return SD_GEN4;
        endcase
    endfunction

    function automatic int unsigned dd_period(input gen_e g);
        case (g)
            GEN3:    return DD_GEN3;
            GEN2:    return DD_GEN2;
            default: return DD_GEN4;
        endcase
    endfunction

endpackage

// File: rtl/rx_clock_div_if.sv
// Lane-aligner side of the receive clock divider: gen select, slip handshake
// and the generated clocks/status.
interface rx_clock_div_if;

    logic [1:0] gen_speed;
    logic       slip_req;
    logic       slip_ack;
    logic       deser_clk;
    logic       dec_clk;
    logic       dec_stb;
    logic       clk_ready;

    modport master (
        output gen_speed, slip_req,
        input  slip_ack, deser_clk, dec_clk, dec_stb, clk_ready
    );

    modport slave (
        input  gen_speed, slip_req,
        output slip_ack, deser_clk, dec_clk, dec_stb, clk_ready
    );

endinterface

// File: rtl/rx_div_counter.sv
// Modulo-N period counter with hold/clear and a registered clock flop that is
// high for the first N/2 counts of each period.
module rx_div_counter #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             local_clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period_i,
    input  logic             hold_i,
    input  logic             clear_i,
    output logic             clk_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    // Counter sits on its last value; the next unheld edge returns it to 0.
    assign wrap_o = (cnt_q == period_i - 1'b1);
    assign clk_o  = clk_q;

    always_comb begin
        cnt_d = cnt_q;
        clk_d = clk_q;
        if (clear_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (!hold_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
            clk_d = (cnt_q < (period_i >> 1));
        end
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

endmodule

// File: rtl/rx_clock_div.sv
// Receive clock generator: derives deser_clk and dec_clk from local_clk with
// one-cycle slip adjustment and glitch-free gen switching.
module rx_clock_div
    import rx_clk_pkg::*;
#(
    parameter int unsigned QUIET_CYC = 8,
    parameter int unsigned CNT_W     = 7
) (
    input logic           local_clk,
    input logic           rst,
    rx_clock_div_if.slave bus
);

    localparam int unsigned    QW         = $clog2(QUIET_CYC);
    localparam logic [QW-1:0]  QUIET_LAST = QW'(QUIET_CYC - 1);

    state_e           state_q, state_d;
    gen_e             gen_q, gen_d;
    logic [QW-1:0]    quiet_q, quiet_d;
    logic             slip_used_q, slip_used_d;
    logic             slip_ack_q, slip_ack_d;
    logic             dec_stb_q, dec_stb_d;
    logic             clk_ready_q, clk_ready_d;
    logic             gen_change, slip_accept;
    logic             dd_clear, sd_clear, dd_wrap, dd_zero_next;
    logic             deser_clk, dec_clk, sd_wrap_unused;
    logic [CNT_W-1:0] sd_per, dd_per;

    assign sd_per = CNT_W'(sd_period(gen_q));
    assign dd_per = CNT_W'(dd_period(gen_q));

    rx_div_counter #(.CNT_W(CNT_W)) u_sd (
        .local_clk (local_clk),
        .rst       (rst),
        .period_i  (sd_per),
        .hold_i    (slip_accept),
        .clear_i   (sd_clear),
        .clk_o     (deser_clk),
        .wrap_o    (sd_wrap_unused)
    );

    rx_div_counter #(.CNT_W(CNT_W)) u_dd (
        .local_clk (local_clk),
        .rst       (rst),
        .period_i  (dd_per),
        .hold_i    (slip_accept),
        .clear_i   (dd_clear),
        .clk_o     (dec_clk),
        .wrap_o    (dd_wrap)
    );

    always_comb begin
        gen_change  = (gen_norm(bus.gen_speed) != gen_q);
        state_d     = state_q;
        gen_d       = gen_q;
        quiet_d     = quiet_q;
        slip_accept = 1'b0;
        dd_clear    = 1'b0;
        case (state_q)
            START, SWITCH: begin
                dd_clear = 1'b1;
                quiet_d  = quiet_q + 1'b1;
                if (quiet_q == QUIET_LAST) begin
                    quiet_d = '0;
                    gen_d   = gen_norm(bus.gen_speed);
                    state_d = RUN;
                end
            end
            RUN: begin
                // dec_stb_q marks dd_cnt==0; slipping there would split strobe and rise
                if (gen_change) state_d = QUIESCE;
                else            slip_accept = bus.slip_req && !slip_used_q && !dec_stb_q;
            end
            QUIESCE: begin
                if (dd_wrap) state_d = SWITCH;
            end
            default: state_d = START;
        endcase
        sd_clear = dd_clear || ((state_q == QUIESCE) && dd_wrap);
    end

    assign dd_zero_next = dd_clear || (dd_wrap && !slip_accept);
    assign slip_used_d  = slip_accept || (slip_used_q && !dd_zero_next);
    assign slip_ack_d   = slip_accept;
    assign dec_stb_d    = (state_d == RUN) && dd_zero_next;
    assign clk_ready_d  = (state_d == RUN);

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= START;
            gen_q       <= GEN4;
            quiet_q     <= '0;
            slip_used_q <= 1'b0;
            slip_ack_q  <= 1'b0;
            dec_stb_q   <= 1'b0;
            clk_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_q       <= gen_d;
            quiet_q     <= quiet_d;
            slip_used_q <= slip_used_d;
            slip_ack_q  <= slip_ack_d;
            dec_stb_q   <= dec_stb_d;
            clk_ready_q <= clk_ready_d;
        end
    end

    assign bus.deser_clk = deser_clk;
    assign bus.dec_clk   = dec_clk;
    assign bus.slip_ack  = slip_ack_q;
    assign bus.dec_stb   = dec_stb_q;
    assign bus.clk_ready = clk_ready_q;

endmodule

// File: tb/tb_rx_clock_div.sv
// Directed bench for rx_clock_div: startup, gen periods, slip handshake,
// gen switching, async reset and 00/11 aliasing.
module tb_rx_clock_div;

    logic local_clk = 1'b0;
    logic rst       = 1'b0;
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;

    rx_clock_div_if bus();

    rx_clock_div #(.QUIET_CYC(8), .CNT_W(7)) dut (
        .local_clk (local_clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 local_clk = ~local_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge local_clk);
        cyc++;
    endtask

    function automatic logic sel(input int which);
        return (which == 0) ? bus.deser_clk : bus.dec_clk;
    endfunction

    task automatic wait_rise(input int which, output int t);
        logic p;
        t = -1;
        for (int n = 0; n < 200; n++) begin
            p = sel(which);
            tick();
            if (!p && sel(which)) begin
                t = cyc;
                break;
            end
        end
        check("rise_seen", (t >= 0) ? 32'd1 : 32'd0, 1);
    endtask

    task automatic wait_ready(input logic lvl, output int t);
        t = -1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (bus.clk_ready === lvl) begin
                t = cyc;
                break;
            end
        end
        check("ready_seen", (t >= 0) ? 32'd1 : 32'd0, 1);
    endtask

    task automatic measure(input int which, output int period, output int high);
        int t0, t1;
        wait_rise(which, t0);
        high = 1;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (sel(which)) high++;
            else break;
        end
        wait_rise(which, t1);
        period = t1 - t0;
    endtask

    initial begin
        int per, hi, t0, t1, t2, t3, tr;
        int n_ack, n_rise, first_ack, second_ack, lowrun, n_stb, n_good, n_bad;
        logic p_stb, p_dec;

        bus.gen_speed = 2'b00;
        bus.slip_req  = 1'b0;
        repeat (3) tick();
        check("rst_deser", bus.deser_clk, 0);
        check("rst_dec",   bus.dec_clk,   0);
        check("rst_stb",   bus.dec_stb,   0);
        check("rst_ack",   bus.slip_ack,  0);
        check("rst_ready", bus.clk_ready, 0);

        // 1: startup quiet window then gen4
        rst = 1'b1;
        cyc = 0;
        n_bad = 0;
        repeat (7) begin
            tick();
            n_bad += int'(bus.deser_clk | bus.dec_clk | bus.clk_ready);
        end
        check("start_quiet", n_bad, 0);
        tick();
        check("run_ready",     bus.clk_ready, 1);
        check("run_first_stb", bus.dec_stb,   1);
        check("run_first_dec", bus.dec_clk,   0);
        tick();
        check("first_dec_rise",   bus.dec_clk,   1);
        check("first_deser_rise", bus.deser_clk, 1);
        measure(1, per, hi);
        check("g4_dec_period", per, 16);
        check("g4_dec_high",   hi,  8);
        measure(0, per, hi);
        check("g4_deser_period", per, 2);
        check("g4_deser_high",   hi,  1);

        // 2: gen3
        bus.gen_speed = 2'b01;
        wait_ready(1'b0, tr);
        wait_ready(1'b1, tr);
        measure(1, per, hi);
        check("g3_dec_period", per, 33);
        check("g3_dec_high",   hi,  16);
        measure(0, per, hi);
        check("g3_deser_period", per, 4);
        check("g3_deser_high",   hi,  2);
        n_stb = 0;
        n_good = 0;
        for (int i = 0; i < 99; i++) begin
            p_stb = bus.dec_stb;
            p_dec = bus.dec_clk;
            tick();
            if (p_stb && !p_dec && bus.dec_clk) n_good++;
            if (bus.dec_stb) n_stb++;
        end
        check("g3_stb_count",   n_stb,  3);
        check("g3_stb_leading", n_good, 3);

        // 3: single slip in gen4
        bus.gen_speed = 2'b00;
        wait_ready(1'b0, tr);
        wait_ready(1'b1, tr);
        wait_rise(1, t0);
        repeat (3) tick();
        bus.slip_req = 1'b1;
        tick();
        bus.slip_req = 1'b0;
        check("slip_ack_pulse", bus.slip_ack, 1);
        tick();
        check("slip_ack_end", bus.slip_ack, 0);
        wait_rise(1, t1);
        wait_rise(1, t2);
        wait_rise(1, t3);
        check("slip_period_stretch", t1 - t0, 17);
        check("slip_period_next",    t2 - t1, 16);
        check("slip_period_after",   t3 - t2, 16);

        // 4: slip_req held high for 50 cycles
        wait_rise(1, t0);
        bus.slip_req = 1'b1;
        n_ack = 0;
        n_rise = 0;
        first_ack = -1;
        second_ack = -1;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 50; i++) begin
            p_dec = bus.dec_clk;
            tick();
            if (bus.slip_ack) begin
                n_ack++;
                if (first_ack < 0)       first_ack  = cyc;
                else if (second_ack < 0) second_ack = cyc;
            end
            if (!p_dec && bus.dec_clk) begin
                n_rise++;
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
        end
        bus.slip_req = 1'b0;
        check("held_ack_count",   n_ack,                   3);
        check("held_ack_first",   first_ack - t0,          1);
        check("held_ack_spacing", second_ack - first_ack,  17);
        check("held_rise_count",  n_rise,                  2);
        check("held_period_a",    t1 - t0,                 17);
        check("held_period_b",    t2 - t1,                 17);

        // 5: gen4 -> gen2 mid-period
        wait_rise(1, t0);
        repeat (3) tick();
        bus.gen_speed = 2'b10;
        tick();
        check("quiesce_ready_low", bus.clk_ready, 0);
        check("quiesce_dec_high",  bus.dec_clk,   1);
        for (int n = 0; n < 100; n++) begin
            if (!bus.dec_clk) break;
            tick();
        end
        check("quiesce_dec_full_high", cyc - t0, 8);
        lowrun = 0;
        t2 = -1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (bus.deser_clk || bus.dec_clk) lowrun = 0;
            else                              lowrun++;
            if (bus.clk_ready) begin
                t2 = cyc;
                break;
            end
        end
        check("switch_run_entry", t2 - t0, 23);
        check("switch_low_run",   lowrun,  9);
        measure(1, per, hi);
        check("g2_dec_period", per, 66);
        check("g2_dec_high",   hi,  33);
        measure(0, per, hi);
        check("g2_deser_period", per, 8);
        check("g2_deser_high",   hi,  4);

        // 6: gen change with slip, then reset during QUIESCE
        wait_rise(1, t0);
        repeat (2) tick();
        bus.gen_speed = 2'b00;
        bus.slip_req  = 1'b1;
        tick();
        check("gen_wins_no_ack", bus.slip_ack,  0);
        check("gen_wins_ready",  bus.clk_ready, 0);
        bus.slip_req = 1'b0;
        tick();
        check("quiesce_no_ack", bus.slip_ack, 0);
        check("pre_reset_dec",  bus.dec_clk,  1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_deser", bus.deser_clk, 0);
        check("async_rst_dec",   bus.dec_clk,   0);
        check("async_rst_stb",   bus.dec_stb,   0);
        check("async_rst_ack",   bus.slip_ack,  0);
        check("async_rst_ready", bus.clk_ready, 0);
        tick();
        rst = 1'b1;
        cyc = 0;
        wait_ready(1'b1, tr);
        check("restart_ready_at", tr, 8);
        measure(1, per, hi);
        check("restart_dec_period", per, 16);

        // 7: 00 -> 11 is not a gen change
        bus.gen_speed = 2'b11;
        n_bad = 0;
        repeat (40) begin
            tick();
            if (!bus.clk_ready) n_bad++;
        end
        check("gen11_no_switch", n_bad, 0);
        measure(1, per, hi);
        check("gen11_dec_period", per, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
